// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the time-shared CLA add/subtract sequencer.
// Holds the FSM state encoding, the adder slice width and saturation patterns.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   localparam int SLICE_WIDTH = 16;
   localparam int SAT_MAXW    = 1024;

   // Most positive (neg=0) or most negative (neg=1) signed value of width w,
   // zero-extended to SAT_MAXW; callers truncate to their own width.
   function automatic logic [SAT_MAXW-1:0] sat_val(input logic neg, input int w);
      logic [SAT_MAXW-1:0] v;
      v = '0;
      for (int i = 0; i < SAT_MAXW; i++) begin
         if (i < w - 1)
            v[i] = ~neg;
         else if (i == w - 1)
            v[i] = neg;
      end
      return v;
   endfunction

endpackage

// File: rtl/multilevel_cla.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups with group generate/propagate,
// a group-level carry network, then bit carries inside each group. Purely combinational.
module multilevel_cla
   import cla_seq_pkg::*;
(
   input  logic [SLICE_WIDTH-1:0] a,
   input  logic [SLICE_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [SLICE_WIDTH-1:0] sum,
   output logic                   cout
);

   localparam int NG = SLICE_WIDTH / 4;

   logic [SLICE_WIDTH-1:0] g, p, c;
   logic [NG-1:0]          gg, gp;
   logic [NG:0]            gc;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      c  = '0;
      gg = '0;
      gp = '0;
      gc = '0;
      for (int k = 0; k < NG; k++) begin
         gp[k] = &p[k*4 +: 4];
         gg[k] = g[k*4+3] | (p[k*4+3] & g[k*4+2]) | ((&p[k*4+2 +: 2]) & g[k*4+1])
               | ((&p[k*4+1 +: 3]) & g[k*4]);
      end
      gc[0] = cin;
      for (int k = 0; k < NG; k++)
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      // Bit carries within each group start from the lookahead group carry.
      for (int k = 0; k < NG; k++) begin
         c[k*4] = gc[k];
         for (int j = 0; j < 3; j++)
            c[k*4+j+1] = g[k*4+j] | (p[k*4+j] & c[k*4+j]);
      end
   end

   assign sum  = p ^ c;
   assign cout = gc[NG];

endmodule

// File: rtl/cla_add_sequencer.sv
// Wide add/subtract that walks one shared 16-bit CLA slice across the operands, LSB first.
// Optional saturation on signed overflow when CLA_SEQ_SAT_EN is defined (adds in_sat port).
module cla_add_sequencer
   import cla_seq_pkg::*;
#(
   parameter int OP_WIDTH = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_WIDTH-1:0] in_a,
   input  logic [OP_WIDTH-1:0] in_b,
   input  logic                in_sub,
`ifdef CLA_SEQ_SAT_EN
   input  logic                in_sat,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OP_WIDTH-1:0] out_sum,
   output logic                out_cout,
   output logic                out_ovf
);

   localparam int NSLICE = OP_WIDTH / SLICE_WIDTH;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   seq_state_e state, state_nxt;

   logic [NSLICE-1:0][SLICE_WIDTH-1:0] a_reg, b_reg, sum_reg;
   logic [IDXW-1:0]                    idx;
   logic                               carry;
   logic [SLICE_WIDTH-1:0]             cla_sum;
   logic                               cla_cout;
   logic                               last, a_msb, b_msb, ovf_nxt;
`ifdef CLA_SEQ_SAT_EN
   logic                               sat_reg;
`endif

   multilevel_cla u_cla (
      .a    (a_reg[idx]),
      .b    (b_reg[idx]),
      .cin  (carry),
      .sum  (cla_sum),
      .cout (cla_cout)
   );

   assign last    = (idx == LAST_IDX);
   assign a_msb   = a_reg[NSLICE-1][SLICE_WIDTH-1];
   assign b_msb   = b_reg[NSLICE-1][SLICE_WIDTH-1];
   assign ovf_nxt = (a_msb == b_msb) && (cla_sum[SLICE_WIDTH-1] != a_msb);
   assign out_sum = sum_reg;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = RUN;
         end
         RUN: begin
            if (last)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as carry-in.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
`ifdef CLA_SEQ_SAT_EN
         sat_reg  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= in_a;
                  b_reg <= in_sub ? ~in_b : in_b;
                  carry <= in_sub;
                  idx   <= '0;
`ifdef CLA_SEQ_SAT_EN
                  sat_reg <= in_sat;
`endif
               end
            end
            RUN: begin
               sum_reg[idx] <= cla_sum;
               carry        <= cla_cout;
               idx          <= idx + 1'b1;
               if (last) begin
                  out_cout <= cla_cout;
                  out_ovf  <= ovf_nxt;
`ifdef CLA_SEQ_SAT_EN
                  if (sat_reg && ovf_nxt)
                     sum_reg <= OP_WIDTH'(sat_val(a_msb, OP_WIDTH));
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Scoreboard bench for cla_add_sequencer: directed cases plus randomized regression
// checked against a signed/unsigned arithmetic reference model.
module tb_cla_add_sequencer;

   localparam int W  = 64;
   localparam int NS = 4;
`ifdef CLA_SEQ_SAT_EN
   localparam bit SAT_BUILD = 1'b1;
`else
   localparam bit SAT_BUILD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_sub, in_sat;
   logic [W-1:0]  in_a, in_b, out_sum;
   logic          out_valid, out_ready, out_cout, out_ovf;
   logic          rdy_rand = 1'b1, rdy_man = 1'b0;
   int            rdy_mode = 0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_fail = 0, cyc = 0;

   cla_add_sequencer #(.OP_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
`ifdef CLA_SEQ_SAT_EN
      .in_sat    (in_sat),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   assign out_ready = (rdy_mode == 2) ? rdy_man : rdy_rand;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      rdy_rand = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] sum, input logic cout, input logic ovf);
      exp_t e;
      e.sum = sum; e.cout = cout; e.ovf = ovf; e.acc = 0;
      return e;
   endfunction

   // Reference: exact signed result in W+1 bits; overflow when it does not fit in W bits.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic sat);
      logic signed [W:0] s;
      logic [W:0]        u;
      exp_t              e;
      if (sub)
         s = $signed({a[W-1], a}) - $signed({b[W-1], b});
      else
         s = $signed({a[W-1], a}) + $signed({b[W-1], b});
      u     = {1'b0, a} + {1'b0, b};
      e.sum = s[W-1:0];
      e.ovf = (s[W] != s[W-1]);
      e.cout = sub ? (a >= b) : u[W];
      if (sat && SAT_BUILD && e.ovf)
         e.sum = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      e.acc = 0;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic sat, input bit use_exp, input exp_t e_in, output int waited);
      exp_t e;
      e = use_exp ? e_in : model(a, b, sub, sat);
      in_a = a; in_b = b; in_sub = sub; in_sat = sat; in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL issue_timeout: in_ready still %b after %0d cycles", in_ready, waited);
         in_valid = 1'b0;
         return;
      end
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = $urandom_range(0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: checks latency on each rising out_valid, pops on each handshake.
   initial begin
      logic prev_v;
      exp_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (out_valid && !prev_v) begin
               if (sb.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL spurious_valid: out_valid=1 with no accepted request");
               end else
                  chk("latency", W'(cyc - sb[0].acc), W'(NS));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
               e = sb.pop_front();
               chk("sum", out_sum, e.sum);
               chk("cout", W'(out_cout), W'(e.cout));
               chk("ovf", W'(out_ovf), W'(e.ovf));
            end
         end
         prev_v = out_valid && !rst;
      end
   end

   initial begin
      int           w;
      exp_t         none;
      logic [W-1:0] hs, ra, rb;
      none = mk('0, 1'b0, 1'b0);
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_sum", out_sum, '0);
      chk("rst_cout", W'(out_cout), W'(0));
      chk("rst_ovf", W'(out_ovf), W'(0));
      rst = 1'b0;
      @(negedge clk);

      // Directed cases with values fixed by hand
      issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
            mk(64'h0000_0001_0000_0000, 1'b0, 1'b0), w);
      issue(64'd5, 64'd7, 1'b1, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0), w);
      issue(64'd7, 64'd5, 1'b1, 1'b0, 1'b1, mk(64'd2, 1'b1, 1'b0), w);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
            mk(64'h8000_0000_0000_0000, 1'b0, 1'b1), w);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1,
            mk(SAT_BUILD ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000, 1'b0, 1'b1), w);
      issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1'b1,
            mk(SAT_BUILD ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1), w);
      drain();

      // Backpressure with a second request waiting
      rdy_mode = 2; rdy_man = 1'b0;
      @(negedge clk);
      issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b0, none, w);
      in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'hFFFF_FFFF_FFFF_FFFF; in_sub = 1'b0;
      in_valid = 1'b1;
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("bp_valid_seen", W'(out_valid), W'(1));
      hs = out_sum;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_sum_stable", out_sum, hs);
         chk("bp_in_ready_low", W'(in_ready), W'(0));
      end
      rdy_man = 1'b1;
      @(negedge clk);
      rdy_man = 1'b0;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1,
            mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0), w);
      chk("bp_accept_next_edge", W'(w), W'(0));
      rdy_mode = 0;
      drain();

      // Reset in the second RUN cycle
      issue(64'hDEAD_BEEF_0000_0001, 64'h1111, 1'b0, 1'b0, 1'b0, none, w);
      @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      chk("midrst_in_ready", W'(in_ready), W'(1));
      chk("midrst_out_valid", W'(out_valid), W'(0));
      chk("midrst_out_sum", out_sum, '0);
      rst = 1'b0;
      @(negedge clk);
      issue(64'd3, 64'd4, 1'b0, 1'b0, 1'b1, mk(64'd7, 1'b0, 1'b0), w);
      drain();

      // Random regression with consumer stalls
      rdy_mode = 1;
      for (int i = 0; i < 1500; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
            1: ra = 64'h8000_0000_0000_0000;
            2: rb = ~ra;
            3: rb = ra;
            default: ;
         endcase
         issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, none, w);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      rdy_mode = 0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
